// File: rtl/cd_ctrl_pkg.sv
// Shared types for the compression/decompression engine arbiter:
// command and response encodings, controller states and default bus widths.
package cd_ctrl_pkg;

  localparam int CD_DATA_W = 80;
  localparam int CD_CODE_W = 8;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_COMP   = 2'b01,
    CMD_DECOMP = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE    = 2'b00,
    RESP_OK      = 2'b01,
    RESP_ERR     = 2'b10,
    RESP_ILLEGAL = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Only compress and decompress ever reach the engine.
  function automatic logic cmd_is_legal(input logic [1:0] cmd);
    return (cmd == CMD_COMP) || (cmd == CMD_DECOMP);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NUM_REQ, reported as one-hot grant plus binary index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int cand_s;

  // Scan requesters starting at ptr and stop at the first valid one.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = int'(ptr) + k;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      if (!any && valid[cand_s]) begin
        any = 1'b1;
        idx = IDX_W'(cand_s);
      end else begin
        any = any;
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/comp_decomp_arbiter.sv
// Round-robin front end that shares one compression/decompression engine among
// NUM_REQ requesters, sequencing each transaction as issue -> wait -> respond.
module comp_decomp_arbiter
  import cd_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = CD_DATA_W,
  parameter int CODE_W  = CD_CODE_W,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_cmd,
  input  logic [DATA_W*NUM_REQ-1:0] req_data_in,
  input  logic [CODE_W*NUM_REQ-1:0] req_compressed_in,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [1:0]                rsp_code,
  output logic [CODE_W-1:0]         rsp_compressed,
  output logic [DATA_W-1:0]         rsp_decompressed,
  output logic [1:0]                eng_command,
  output logic [DATA_W-1:0]         eng_data_in,
  output logic [CODE_W-1:0]         eng_compressed_in,
  input  logic [CODE_W-1:0]         eng_compressed_out,
  input  logic [DATA_W-1:0]         eng_decompressed_out,
  input  logic [1:0]                eng_response,
  output logic                      busy,
  output logic [7:0]                timeout_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e                 state_r;
  logic [IDX_W-1:0]       ptr_r;
  logic [IDX_W-1:0]       id_r;
  cmd_e                   cmd_r;
  logic [TMR_W-1:0]       tmr_r;
  logic [NUM_REQ-1:0]     sel_grant_s;
  logic [IDX_W-1:0]       sel_idx_s;
  logic                   sel_any_s;
  logic [1:0]             sel_cmd_s;
  logic [IDX_W-1:0]       next_ptr_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (ptr_r),
    .grant (sel_grant_s),
    .idx   (sel_idx_s),
    .any   (sel_any_s)
  );

  // Selected command and the pointer value that follows the current owner.
  always_comb begin
    sel_cmd_s = req_cmd[2*sel_idx_s +: 2];
    if (id_r == IDX_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = id_r + IDX_W'(1);
    end
  end

  // Transaction FSM; every output is a register so reset clears them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      ptr_r             <= '0;
      id_r              <= '0;
      cmd_r             <= CMD_NOP;
      tmr_r             <= '0;
      req_ready         <= '0;
      rsp_valid         <= '0;
      rsp_code          <= 2'b00;
      rsp_compressed    <= '0;
      rsp_decompressed  <= '0;
      eng_command       <= 2'b00;
      eng_data_in       <= '0;
      eng_compressed_in <= '0;
      busy              <= 1'b0;
      timeout_cnt       <= 8'd0;
    end else begin
      req_ready   <= '0;
      rsp_valid   <= '0;
      eng_command <= CMD_NOP;
      case (state_r)
        ST_IDLE: begin
          if (sel_any_s) begin
            id_r              <= sel_idx_s;
            cmd_r             <= cmd_e'(sel_cmd_s);
            eng_data_in       <= req_data_in[sel_idx_s*DATA_W +: DATA_W];
            eng_compressed_in <= req_compressed_in[sel_idx_s*CODE_W +: CODE_W];
            req_ready         <= sel_grant_s;
            eng_command       <= cmd_is_legal(sel_cmd_s) ? sel_cmd_s : 2'b00;
            busy              <= 1'b1;
            state_r           <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // Anything the engine reports during issue is deliberately not looked at.
          if (cmd_is_legal(cmd_r)) begin
            tmr_r   <= '0;
            state_r <= ST_WAIT;
          end else begin
            rsp_code         <= RESP_ILLEGAL;
            rsp_compressed   <= '0;
            rsp_decompressed <= '0;
            rsp_valid        <= ONE_HOT0 << id_r;
            state_r          <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (eng_response != RESP_NONE) begin
            rsp_code         <= (eng_response == RESP_ILLEGAL) ? RESP_ERR : eng_response;
            rsp_compressed   <= eng_compressed_out;
            rsp_decompressed <= eng_decompressed_out;
            rsp_valid        <= ONE_HOT0 << id_r;
            state_r          <= ST_RESP;
          end else if (tmr_r == TMR_W'(TIMEOUT - 1)) begin
            rsp_code         <= RESP_ERR;
            rsp_compressed   <= '0;
            rsp_decompressed <= '0;
            rsp_valid        <= ONE_HOT0 << id_r;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end else begin
              timeout_cnt <= timeout_cnt;
            end
            state_r <= ST_RESP;
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        ST_RESP: begin
          ptr_r   <= next_ptr_s;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_decomp_arbiter.sv
// Directed self-checking bench for comp_decomp_arbiter: each task drives one
// scenario and compares observed outputs against hand-computed values.
module tb_comp_decomp_arbiter;

  localparam int NR = 4;
  localparam int DW = 80;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [2*NR-1:0]   req_cmd;
  logic [DW*NR-1:0]  req_data_in;
  logic [CW*NR-1:0]  req_compressed_in;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [1:0]        rsp_code;
  logic [CW-1:0]     rsp_compressed;
  logic [DW-1:0]     rsp_decompressed;
  logic [1:0]        eng_command;
  logic [DW-1:0]     eng_data_in;
  logic [CW-1:0]     eng_compressed_in;
  logic [CW-1:0]     eng_compressed_out;
  logic [DW-1:0]     eng_decompressed_out;
  logic [1:0]        eng_response;
  logic              busy;
  logic [7:0]        timeout_cnt;

  int checks = 0;
  int errors = 0;

  comp_decomp_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CODE_W(CW), .TIMEOUT(64)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_cmd              (req_cmd),
    .req_data_in          (req_data_in),
    .req_compressed_in    (req_compressed_in),
    .req_ready            (req_ready),
    .rsp_valid            (rsp_valid),
    .rsp_code             (rsp_code),
    .rsp_compressed       (rsp_compressed),
    .rsp_decompressed     (rsp_decompressed),
    .eng_command          (eng_command),
    .eng_data_in          (eng_data_in),
    .eng_compressed_in    (eng_compressed_in),
    .eng_compressed_out   (eng_compressed_out),
    .eng_decompressed_out (eng_decompressed_out),
    .eng_response         (eng_response),
    .busy                 (busy),
    .timeout_cnt          (timeout_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the number of negedges until req_ready[id] rises, -1 if it never does.
  task automatic wait_ready(input int id, output int n);
    n = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[id] === 1'b1) begin
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic wait_any_ready(output logic [NR-1:0] r);
    r = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        r = req_ready;
        break;
      end
    end
  endtask

  // Engine stand-in: quiet for lat-1 cycles after issue, then one response cycle.
  task automatic engine_reply(input int lat, input logic [1:0] resp,
                              input logic [CW-1:0] co, input logic [DW-1:0] dout);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      eng_response = 2'b00;
    end
    eng_response         = resp;
    eng_compressed_out   = co;
    eng_decompressed_out = dout;
  endtask

  // Negedges until rsp_valid rises (engine response cleared each cycle), -1 on budget.
  task automatic wait_rsp(output int n, output logic [NR-1:0] v);
    n = -1;
    v = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      eng_response = 2'b00;
      if (rsp_valid !== '0) begin
        n = i + 1;
        v = rsp_valid;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    req_cmd = '0;
    req_data_in = '0;
    req_compressed_in = '0;
    eng_compressed_out = '0;
    eng_decompressed_out = '0;
    eng_response = 2'b00;
    tick(2);
    checks++;
    if (req_ready !== 4'h0 || rsp_valid !== 4'h0) begin
      errors++;
      $display("FAIL reset_pulses: ready=%b rsp_valid=%b expected 0000/0000", req_ready, rsp_valid);
    end
    checks++;
    if (eng_command !== 2'b00 || busy !== 1'b0 || timeout_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: cmd=%b busy=%b tcnt=%0d expected 00/0/0", eng_command, busy, timeout_cnt);
    end
    checks++;
    if (rsp_code !== 2'b00 || rsp_compressed !== 8'h00 || rsp_decompressed !== 80'h0) begin
      errors++;
      $display("FAIL reset_rsp: code=%b comp=%h expected 00/00", rsp_code, rsp_compressed);
    end
    reset = 1'b0;
  endtask

  task automatic test_compress();
    int n;
    logic [NR-1:0] v;
    req_valid = 4'b0001;
    req_cmd[1:0] = 2'b01;
    req_data_in[79:0] = {80{1'b1}};
    wait_ready(0, n);
    checks++;
    if (n !== 1 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL comp_ready: after %0d cycles ready=%b expected 1 cycle 0001", n, req_ready);
    end
    checks++;
    if (eng_command !== 2'b01 || eng_data_in !== {80{1'b1}} || busy !== 1'b1) begin
      errors++;
      $display("FAIL comp_issue: cmd=%b data=%h busy=%b expected 01/all-ones/1", eng_command, eng_data_in, busy);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (eng_command !== 2'b00 || req_ready !== 4'b0000 || eng_data_in !== {80{1'b1}}) begin
      errors++;
      $display("FAIL comp_wait: cmd=%b ready=%b data=%h expected 00/0000/held", eng_command, req_ready, eng_data_in);
    end
    engine_reply(1, 2'b01, 8'hF0, 80'h0);
    wait_rsp(n, v);
    checks++;
    if (n !== 1 || v !== 4'b0001 || rsp_code !== 2'b01 || rsp_compressed !== 8'hF0) begin
      errors++;
      $display("FAIL comp_rsp: n=%0d v=%b code=%b comp=%h expected 1/0001/01/f0", n, v, rsp_code, rsp_compressed);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_code !== 2'b01 || rsp_compressed !== 8'hF0) begin
      errors++;
      $display("FAIL comp_hold: v=%b busy=%b code=%b comp=%h expected 0000/0/01/f0", rsp_valid, busy, rsp_code, rsp_compressed);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] r;
    logic [NR-1:0] v;
    int n;
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      req_cmd[2*i +: 2] = 2'b01;
      req_data_in[i*DW +: DW] = DW'(i + 1);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_any_ready(r);
      if (k == 4) req_valid = '0;
      checks++;
      if (r !== (4'b0001 << order[k]) || eng_data_in !== DW'(order[k] + 1)) begin
        errors++;
        $display("FAIL rr_grant%0d: ready=%b data=%h expected %b/%0d", k, r, eng_data_in, 4'b0001 << order[k], order[k] + 1);
      end
      engine_reply(1, 2'b01, 8'(8'h10 + k), 80'h0);
      wait_rsp(n, v);
      checks++;
      if (v !== (4'b0001 << order[k]) || rsp_compressed !== 8'(8'h10 + k)) begin
        errors++;
        $display("FAIL rr_rsp%0d: rsp_valid=%b comp=%h expected %b/%h", k, v, rsp_compressed, 4'b0001 << order[k], 8'(8'h10 + k));
      end
    end
    tick(1);
  endtask

  task automatic test_timeout();
    int n;
    logic [NR-1:0] v;
    req_valid = 4'b1000;
    req_cmd[7:6] = 2'b01;
    wait_ready(3, n);
    req_valid = '0;
    wait_rsp(n, v);
    checks++;
    if (n !== 65 || v !== 4'b1000) begin
      errors++;
      $display("FAIL to_latency: %0d cycles v=%b expected 65/1000", n, v);
    end
    checks++;
    if (rsp_code !== 2'b10 || rsp_compressed !== 8'h00 || rsp_decompressed !== 80'h0 || timeout_cnt !== 8'd1) begin
      errors++;
      $display("FAIL to_rsp: code=%b comp=%h tcnt=%0d expected 10/00/1", rsp_code, rsp_compressed, timeout_cnt);
    end
    eng_response = 2'b01;
    eng_compressed_out = 8'h55;
    tick(1);
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_late: rsp_valid=%b busy=%b expected 0000/0", rsp_valid, busy);
    end
    tick(1);
    eng_response = 2'b00;
    checks++;
    if (rsp_code !== 2'b10 || rsp_compressed !== 8'h00 || timeout_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_ignored: code=%b comp=%h tcnt=%0d busy=%b expected 10/00/1/0", rsp_code, rsp_compressed, timeout_cnt, busy);
    end
  endtask

  task automatic test_illegal();
    int ids [2] = '{2, 1};
    logic [1:0] cmds [2] = '{2'b11, 2'b00};
    for (int t = 0; t < 2; t++) begin
      logic bad;
      logic [NR-1:0] got;
      logic [1:0] code;
      bad = 1'b0;
      got = '0;
      code = 2'b00;
      req_cmd[2*ids[t] +: 2] = cmds[t];
      req_valid = 4'b0001 << ids[t];
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (eng_command !== 2'b00) bad = 1'b1;
        if (req_ready[ids[t]] === 1'b1) req_valid = '0;
        if (rsp_valid !== '0 && got === '0) begin
          got = rsp_valid;
          code = rsp_code;
        end
      end
      checks++;
      if (bad !== 1'b0 || got !== (4'b0001 << ids[t]) || code !== 2'b11) begin
        errors++;
        $display("FAIL illegal_cmd%b: engine_touched=%b rsp_valid=%b code=%b expected 0/%b/11", cmds[t], bad, got, code, 4'b0001 << ids[t]);
      end
    end
  endtask

  task automatic test_decompress();
    int n;
    logic [NR-1:0] v;
    logic [DW-1:0] dval;
    dval = 80'h1234_5678_9ABC_DEF0_1357;
    req_cmd[3:2] = 2'b10;
    req_compressed_in[15:8] = 8'h03;
    req_valid = 4'b0010;
    wait_ready(1, n);
    req_valid = '0;
    checks++;
    if (eng_command !== 2'b10 || eng_compressed_in !== 8'h03) begin
      errors++;
      $display("FAIL dec_issue: cmd=%b code_in=%h expected 10/03", eng_command, eng_compressed_in);
    end
    eng_response = 2'b01;
    engine_reply(3, 2'b10, 8'h77, dval);
    wait_rsp(n, v);
    checks++;
    if (n !== 1 || v !== 4'b0010 || rsp_code !== 2'b10 || rsp_decompressed !== dval || rsp_compressed !== 8'h77) begin
      errors++;
      $display("FAIL dec_rsp: n=%0d v=%b code=%b dec=%h expected 1/0010/10/%h", n, v, rsp_code, rsp_decompressed, dval);
    end
    req_cmd[1:0] = 2'b01;
    req_valid = 4'b0001;
    wait_ready(0, n);
    req_valid = '0;
    engine_reply(2, 2'b11, 8'h22, 80'h0);
    wait_rsp(n, v);
    checks++;
    if (v !== 4'b0001 || rsp_code !== 2'b10 || rsp_compressed !== 8'h22) begin
      errors++;
      $display("FAIL resp11_map: v=%b code=%b comp=%h expected 0001/10/22", v, rsp_code, rsp_compressed);
    end
    tick(1);
  endtask

  task automatic test_reset_mid();
    int n;
    logic [NR-1:0] r;
    logic [NR-1:0] v;
    logic seen;
    req_cmd[5:4] = 2'b01;
    req_valid = 4'b0100;
    wait_ready(2, n);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (eng_command !== 2'b00 || busy !== 1'b0 || rsp_valid !== 4'b0000 || timeout_cnt !== 8'd0 || eng_data_in !== 80'h0) begin
      errors++;
      $display("FAIL rst_mid: cmd=%b busy=%b v=%b tcnt=%0d expected 00/0/0000/0", eng_command, busy, rsp_valid, timeout_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    eng_response = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      eng_response = 2'b00;
      if (rsp_valid !== '0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: activity=%b expected 0", seen);
    end
    for (int i = 0; i < NR; i++) req_cmd[2*i +: 2] = 2'b01;
    req_valid = 4'b1111;
    wait_any_ready(r);
    req_valid = '0;
    checks++;
    if (r !== 4'b0001) begin
      errors++;
      $display("FAIL rst_ptr: ready=%b expected 0001", r);
    end
    engine_reply(1, 2'b01, 8'h3C, 80'h0);
    wait_rsp(n, v);
    checks++;
    if (v !== 4'b0001 || rsp_code !== 2'b01) begin
      errors++;
      $display("FAIL rst_resume: v=%b code=%b expected 0001/01", v, rsp_code);
    end
  endtask

  initial begin
    test_reset();
    test_compress();
    test_round_robin();
    test_timeout();
    test_illegal();
    test_decompress();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
